// File: rtl/fc_output_collector.sv
// fc_output_collector
// Collects finished neuron results from the FC MAC kernel into a per-layer
// buffer indexed by neuron id. It can apply ReLU and records a ReLU derivative
// mask for backprop. Once every neuron has been written, it streams the layer
// in neuron order over valid/ready and then rearms for the next sample.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   act_i, id_i     activation / neuron id from the kernel, qualified by valid_i
//   ready_i         downstream accepts data_o this cycle
//   mask_addr_i     ReLU-mask read address; mask_o follows one cycle later
//   clear_err_i     clears the sticky error flags
//   data_o, idx_o   streamed activation and its neuron index, qualified by valid_o
//   last_o          marks the final element of the stream
//   mask_o          registered ReLU derivative of neuron mask_addr_i
//   drop_err_o      sticky: a write arrived while draining
//   id_err_o        sticky: a write used an out-of-range id
//   dup_err_o       sticky: one id was written twice in one fill

`ifndef PREC
`define PREC 18
`endif

module fc_output_collector #(
  parameter int unsigned N_NEURONS = 10,
  parameter int unsigned ID_WIDTH  = 4,
  parameter bit          RELU_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [`PREC-1:0]    act_i,
  input  logic        [ID_WIDTH-1:0] id_i,
  input  logic                       valid_i,
  input  logic                       ready_i,
  input  logic        [ID_WIDTH-1:0] mask_addr_i,
  input  logic                       clear_err_i,
  output logic signed [`PREC-1:0]    data_o,
  output logic        [ID_WIDTH-1:0] idx_o,
  output logic                       valid_o,
  output logic                       last_o,
  output logic                       mask_o,
  output logic                       drop_err_o,
  output logic                       id_err_o,
  output logic                       dup_err_o
);

  localparam int unsigned PREC_W = `PREC;
  localparam int unsigned PTR_W  = (N_NEURONS <= 1) ? 1 : $clog2(N_NEURONS);
  localparam int unsigned CNT_W  = $clog2(N_NEURONS + 1);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic signed [PREC_W-1:0] mem_q [N_NEURONS];
  logic [N_NEURONS-1:0]     written_q;
  logic [N_NEURONS-1:0]     mask_q;
  logic [CNT_W-1:0]         fill_cnt_q;
  logic [PTR_W-1:0]         rd_ptr_q;

  logic                     id_ok_c;
  logic [PTR_W-1:0]         wr_addr_c;
  logic                     fill_full_c;
  logic                     hs_c;
  logic                     at_end_c;
  logic [PTR_W-1:0]         rd_nxt_c;

  logic                     wr_en_c;
  logic                     dup_c;
  logic                     drop_c;
  logic                     bad_id_c;
  logic                     load_first_c;
  logic                     advance_c;
  logic                     finish_c;
  logic signed [PREC_W-1:0] store_val_c;
  logic                     store_mask_c;
  logic                     mask_rd_c;

  assign id_ok_c     = 32'(id_i) < N_NEURONS;
  assign wr_addr_c   = PTR_W'(id_i);
  assign fill_full_c = (fill_cnt_q == CNT_W'(N_NEURONS));
  assign hs_c        = valid_o && ready_i;
  assign at_end_c    = (rd_ptr_q == PTR_W'(N_NEURONS - 1));
  assign rd_nxt_c    = rd_ptr_q + PTR_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FILL;
    else      state_q <= state_d;
  end

  // Next-state: leave FILL one edge after the count is full; return on the last handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (fill_full_c)      state_d = S_DRAIN;
      S_DRAIN: if (hs_c && at_end_c) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Control decode and ReLU datapath
  always_comb begin
    wr_en_c      = 1'b0;
    dup_c        = 1'b0;
    drop_c       = 1'b0;
    bad_id_c     = 1'b0;
    load_first_c = 1'b0;
    advance_c    = 1'b0;
    finish_c     = 1'b0;
    store_val_c  = act_i;
    store_mask_c = 1'b1;
    mask_rd_c    = 1'b0;

    bad_id_c = valid_i && !id_ok_c;
    case (state_q)
      S_FILL: begin
        wr_en_c      = valid_i && id_ok_c;
        dup_c        = wr_en_c && written_q[wr_addr_c];
        load_first_c = fill_full_c;
      end
      S_DRAIN: begin
        drop_c    = valid_i;
        advance_c = hs_c && !at_end_c;
        finish_c  = hs_c && at_end_c;
      end
      default: ;
    endcase

    if (RELU_EN) begin
      if (act_i[PREC_W-1]) store_val_c = '0;
      store_mask_c = !act_i[PREC_W-1] && (act_i != '0);
    end

    // Out-of-range mask addresses read as zero
    if (32'(mask_addr_i) < N_NEURONS) mask_rd_c = mask_q[PTR_W'(mask_addr_i)];
  end

  // Activation buffer; contents only reach data_o after a complete fill
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_addr_c] <= store_val_c;
  end

  // Fill bookkeeping, stream registers, mask and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written_q  <= '0;
      mask_q     <= '0;
      fill_cnt_q <= '0;
      rd_ptr_q   <= '0;
      data_o     <= '0;
      idx_o      <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      mask_o     <= 1'b0;
      drop_err_o <= 1'b0;
      id_err_o   <= 1'b0;
      dup_err_o  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        written_q[wr_addr_c] <= 1'b1;
        mask_q[wr_addr_c]    <= store_mask_c;
      end

      if (finish_c) begin
        written_q  <= '0;
        fill_cnt_q <= '0;
      end else if (wr_en_c && !dup_c) begin
        fill_cnt_q <= fill_cnt_q + CNT_W'(1);
      end

      if (load_first_c) begin
        rd_ptr_q <= '0;
        data_o   <= mem_q[0];
        idx_o    <= '0;
        valid_o  <= 1'b1;
        last_o   <= (N_NEURONS == 1);
      end else if (advance_c) begin
        // Prefetch the next element on the handshake edge for one beat per cycle
        rd_ptr_q <= rd_nxt_c;
        data_o   <= mem_q[rd_nxt_c];
        idx_o    <= ID_WIDTH'(rd_nxt_c);
        last_o   <= (rd_nxt_c == PTR_W'(N_NEURONS - 1));
      end else if (finish_c) begin
        valid_o  <= 1'b0;
        last_o   <= 1'b0;
      end

      mask_o <= mask_rd_c;

      // A same-cycle error event overrides the clear
      drop_err_o <= drop_c   || (drop_err_o && !clear_err_i);
      id_err_o   <= bad_id_c || (id_err_o   && !clear_err_i);
      dup_err_o  <= dup_c    || (dup_err_o  && !clear_err_i);
    end
  end

endmodule

// File: tb/tb_fc_output_collector.sv
`ifndef PREC
`define PREC 18
`endif

module tb_fc_output_collector;

  localparam int unsigned P = `PREC;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] act_i;
  logic [3:0]   id_i;
  logic         valid_i;
  logic         ready_i;
  logic [3:0]   mask_addr_i;
  logic         clear_err_i;
  logic [P-1:0] data_o;
  logic [3:0]   idx_o;
  logic         valid_o;
  logic         last_o;
  logic         mask_o;
  logic         drop_err_o;
  logic         id_err_o;
  logic         dup_err_o;

  fc_output_collector #(
    .N_NEURONS(10),
    .ID_WIDTH (4),
    .RELU_EN  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .act_i      (act_i),
    .id_i       (id_i),
    .valid_i    (valid_i),
    .ready_i    (ready_i),
    .mask_addr_i(mask_addr_i),
    .clear_err_i(clear_err_i),
    .data_o     (data_o),
    .idx_o      (idx_o),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .mask_o     (mask_o),
    .drop_err_o (drop_err_o),
    .id_err_o   (id_err_o),
    .dup_err_o  (dup_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [P-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [P-1:0] exp_v [10];
  int           checks = 0;
  int           errors = 0;
  int           hs_count = 0;
  logic         stalled = 1'b0;
  logic [P-1:0] hold_data;
  logic [3:0]   hold_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one write for the current cycle; returns 1ns after the capturing edge
  task automatic wr(input logic [3:0] id, input logic [P-1:0] v);
    valid_i = 1'b1;
    id_i    = id;
    act_i   = v;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      e.data = exp_v[i];
      e.idx  = 4'(i);
      e.last = (i == 9);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    while (hs_count < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(hs_count >= target), 32'd1);
  endtask

  task automatic read_mask(input logic [3:0] a, input logic want, input string name);
    mask_addr_i = a;
    @(posedge clk); #1;
    check(name, 32'(mask_o), 32'(want));
  endtask

  task automatic clr_err();
    clear_err_i = 1'b1;
    @(posedge clk); #1;
    clear_err_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        if (stalled) begin
          check("hold_data", 32'(data_o), 32'(hold_data));
          check("hold_idx", 32'(idx_o), 32'(hold_idx));
        end
        if (ready_i) begin
          hs_count++;
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(idx_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(data_o), 32'(e.data));
            check("beat_idx", 32'(idx_o), 32'(e.idx));
            check("beat_last", 32'(last_o), 32'(e.last));
          end
        end else begin
          stalled   = 1'b1;
          hold_data = data_o;
          hold_idx  = idx_o;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int base;
    int n;
    rst = 1'b0;
    act_i = '0; id_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    mask_addr_i = '0; clear_err_i = 1'b0;

    // Reset values
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_mask", 32'(mask_o), 32'd0);
    check("rst_errs", 32'({drop_err_o, id_err_o, dup_err_o}), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // In-order fill with one negative value, ready held high
    ready_i = 1'b1;
    base = hs_count;
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = P'(i * 256);
      wr(4'(i), (i == 3) ? 18'h3FF00 : P'(i * 256));
    end
    exp_v[3] = '0;
    push_all();
    check("t1_lat_t1", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    check("t1_lat_t2", 32'(valid_o), 32'd1);
    wait_hs(base + 10, "t1_drain_done");
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_valid_low", 32'(valid_o), 32'd0);
    read_mask(4'd3, 1'b0, "t1_mask3");
    read_mask(4'd5, 1'b1, "t1_mask5");
    read_mask(4'd0, 1'b0, "t1_mask0");
    read_mask(4'd9, 1'b1, "t1_mask9");
    read_mask(4'd12, 1'b0, "t1_mask_oob");

    // Reverse-order fill, ready toggling every cycle
    ready_i = 1'b0;
    base = hs_count;
    for (int i = 9; i >= 0; i--) begin
      exp_v[i] = P'(32'h1000 + i);
      wr(4'(i), P'(32'h1000 + i));
    end
    push_all();
    n = 0;
    while (hs_count < base + 10 && n < 100) begin
      @(posedge clk); #1;
      ready_i = ~ready_i;
      n++;
    end
    ready_i = 1'b1;
    cyc(5);
    check("t2_hs_count", 32'(hs_count - base), 32'd10);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Duplicate id 4 among ten distinct ids
    base = hs_count;
    for (int i = 0; i < 10; i++) exp_v[i] = P'(32'h50 + i);
    exp_v[4] = P'(32'h20);
    for (int i = 0; i < 10; i++) begin
      wr(4'(i), (i == 4) ? P'(32'h10) : P'(32'h50 + i));
      if (i == 5) wr(4'd4, P'(32'h20));
    end
    check("t3_dup_err", 32'(dup_err_o), 32'd1);
    check("t3_lat_t1", 32'(valid_o), 32'd0);
    push_all();
    wait_hs(base + 10, "t3_drain_done");
    clr_err();
    check("t3_dup_clear", 32'(dup_err_o), 32'd0);

    // Writes during DRAIN and on the final-handshake cycle are dropped
    ready_i = 1'b0;
    base = hs_count;
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = P'(32'h200 + i);
      wr(4'(i), P'(32'h200 + i));
    end
    push_all();
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_drain_start", 32'(valid_o), 32'd1);
    wr(4'd2, P'(32'h7777));
    check("t4_drop_err", 32'(drop_err_o), 32'd1);
    clr_err();
    check("t4_drop_clear", 32'(drop_err_o), 32'd0);
    ready_i = 1'b1;
    n = 0;
    while (!(valid_o && idx_o == 4'd9) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_reach_last", 32'(idx_o), 32'd9);
    valid_i = 1'b1; id_i = 4'd1; act_i = P'(32'h6666);
    @(posedge clk); #1;
    check("t4_after_last", 32'(valid_o), 32'd0);
    id_i = 4'd0; act_i = P'(32'h1234);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("t4_drop_final", 32'(drop_err_o), 32'd1);
    wait_hs(base + 10, "t4_drain_done");
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    clr_err();

    // Out-of-range id does not count; id 0 already accepted after the drain
    base = hs_count;
    wr(4'd12, P'(32'h5555));
    check("t5_id_err", 32'(id_err_o), 32'd1);
    exp_v[0] = P'(32'h1234);
    for (int i = 1; i < 10; i++) begin
      exp_v[i] = P'(32'h300 + i);
      wr(4'(i), P'(32'h300 + i));
    end
    check("t5_lat_t1", 32'(valid_o), 32'd0);
    push_all();
    wait_hs(base + 10, "t5_drain_done");
    clear_err_i = 1'b1;
    wr(4'd13, '0);
    clear_err_i = 1'b0;
    check("t5_err_wins", 32'(id_err_o), 32'd1);
    clr_err();
    check("t5_id_clear", 32'(id_err_o), 32'd0);
    read_mask(4'd0, 1'b1, "t5_mask0");

    // Reset in the middle of a drain
    wr(4'd15, P'(32'h1));
    check("t7_id_err", 32'(id_err_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = P'(32'h400 + i);
      wr(4'(i), P'(32'h400 + i));
    end
    push_all();
    n = 0;
    while (!(valid_o && idx_o == 4'd5) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_reach_5", 32'(idx_o), 32'd5);
    rst = 1'b0;
    #1;
    check("t7_rst_valid", 32'(valid_o), 32'd0);
    check("t7_rst_idx", 32'(idx_o), 32'd0);
    check("t7_rst_data", 32'(data_o), 32'd0);
    check("t7_rst_errs", 32'({drop_err_o, id_err_o, dup_err_o}), 32'd0);
    exp_q.delete();
    #2 rst = 1'b1;
    cyc(3);
    check("t7_no_resume", 32'(valid_o), 32'd0);
    read_mask(4'd5, 1'b0, "t7_mask_rst");
    base = hs_count;
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = P'(32'h30 + i);
      wr(4'(i), (i == 7) ? 18'h20000 : P'(32'h30 + i));
    end
    exp_v[7] = '0;
    check("t7_lat_t1", 32'(valid_o), 32'd0);
    push_all();
    @(posedge clk); #1;
    check("t7_lat_t2", 32'(valid_o), 32'd1);
    wait_hs(base + 10, "t7_drain_done");
    check("t7_q_empty", 32'(exp_q.size()), 32'd0);
    read_mask(4'd7, 1'b0, "t7_mask7");
    read_mask(4'd6, 1'b1, "t7_mask6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
